// File: rtl/deb_uart_framer_if.sv
// Bus between the debug UART framer, its PISO source and the frame requester.
// master: the framer side; slave: the PISO/requester side.
interface deb_uart_framer_if;
    logic       DEB_REQ;
    logic [7:0] D_IN;
    logic       EN_PISO_DEB;
    logic       SHIFT_DEB;
    logic       CLR_PISO_DEB;
    logic       TXD;
    logic       BUSY;
    logic       DONE;

    modport master (
        input  DEB_REQ,
        input  D_IN,
        output EN_PISO_DEB,
        output SHIFT_DEB,
        output CLR_PISO_DEB,
        output TXD,
        output BUSY,
        output DONE
    );

    modport slave (
        output DEB_REQ,
        output D_IN,
        input  EN_PISO_DEB,
        input  SHIFT_DEB,
        input  CLR_PISO_DEB,
        input  TXD,
        input  BUSY,
        input  DONE
    );
endinterface

// File: rtl/deb_uart_framer.sv
// Pulls N_BYTES from the debug PISO and sends SYNC + payload + XOR checksum on a UART 8N1 line.
// Optional macro DEB_FRAME_CNT_EN: inserts an 8-bit frame counter byte right after SYNC.
module deb_uart_framer #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int unsigned N_BYTES      = 12
) (
    input  logic               CLKEXT,
    input  logic               RST_GLO,
    deb_uart_framer_if.master  bus
);

    localparam int unsigned    BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned    CNT_W     = $clog2(N_BYTES + 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(N_BYTES);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_TX,
        S_SHIFT,
        S_CAPT,
        S_FIN
    } state_t;

    typedef enum logic [1:0] {
        SEL_SYNC,
        SEL_FCNT,
        SEL_DATA,
        SEL_CSUM
    } sel_t;

    state_t            state;
    state_t            state_nx;
    sel_t              tx_sel;
    logic [7:0]        tx_byte;
    logic [7:0]        csum;
    logic [3:0]        bit_cnt;
    logic [BAUD_W-1:0] baud_cnt;
    logic [CNT_W-1:0]  byte_cnt;
    logic [2:0]        data_idx;
    logic              bit_end;
    logic              tx_end;
    logic              start_fcnt;
    logic              start_csum;
`ifdef DEB_FRAME_CNT_EN
    logic [7:0]        frame_cnt;
`endif

    assign bit_end  = (baud_cnt == BAUD_LAST);
    assign tx_end   = bit_end && (bit_cnt == 4'd9);
    assign data_idx = 3'(bit_cnt - 4'd1);

    always_ff @(posedge CLKEXT) begin
        if (RST_GLO) begin
            state     <= S_IDLE;
            tx_sel    <= SEL_SYNC;
            tx_byte   <= '0;
            csum      <= '0;
            bit_cnt   <= '0;
            baud_cnt  <= '0;
            byte_cnt  <= '0;
`ifdef DEB_FRAME_CNT_EN
            frame_cnt <= '0;
`endif
        end else begin
            state <= state_nx;
            case (state)
                S_LOAD: begin
                    csum     <= '0;
                    byte_cnt <= '0;
                    tx_byte  <= SYNC_BYTE;
                    tx_sel   <= SEL_SYNC;
                    bit_cnt  <= '0;
                    baud_cnt <= '0;
                end
                S_TX: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_cnt  <= (bit_cnt == 4'd9) ? 4'd0 : bit_cnt + 4'd1;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_ONE;
                    end
`ifdef DEB_FRAME_CNT_EN
                    if (start_fcnt) begin
                        tx_byte <= frame_cnt;
                        csum    <= csum ^ frame_cnt;
                        tx_sel  <= SEL_FCNT;
                    end
`endif
                    if (start_csum) begin
                        tx_byte <= csum;
                        tx_sel  <= SEL_CSUM;
                    end
                end
                S_CAPT: begin
                    tx_byte  <= bus.D_IN;
                    csum     <= csum ^ bus.D_IN;
                    byte_cnt <= byte_cnt + CNT_ONE;
                    tx_sel   <= SEL_DATA;
                    bit_cnt  <= '0;
                    baud_cnt <= '0;
                end
`ifdef DEB_FRAME_CNT_EN
                S_FIN: frame_cnt <= frame_cnt + 8'd1;
`endif
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx         = state;
        start_fcnt       = 1'b0;
        start_csum       = 1'b0;
        bus.EN_PISO_DEB  = 1'b0;
        bus.SHIFT_DEB    = 1'b0;
        bus.CLR_PISO_DEB = 1'b0;
        bus.BUSY         = 1'b0;
        bus.DONE         = 1'b0;
        bus.TXD          = 1'b1;
        unique case (state)
            S_IDLE: begin
                if (bus.DEB_REQ) state_nx = S_LOAD;
            end
            S_LOAD: begin
                bus.EN_PISO_DEB = 1'b1;
                bus.BUSY        = 1'b1;
                state_nx        = S_TX;
            end
            S_TX: begin
                bus.BUSY = 1'b1;
                case (bit_cnt)
                    4'd0:    bus.TXD = 1'b0;
                    4'd9:    bus.TXD = 1'b1;
                    default: bus.TXD = tx_byte[data_idx];
                endcase
                // The frame counter follows SYNC back-to-back, skipping the PISO handshake.
                if (tx_end) begin
                    if (tx_sel == SEL_CSUM) state_nx = S_FIN;
`ifdef DEB_FRAME_CNT_EN
                    else if (tx_sel == SEL_SYNC) start_fcnt = 1'b1;
`endif
                    else if (byte_cnt < CNT_LAST) state_nx = S_SHIFT;
                    else start_csum = 1'b1;
                end
            end
            S_SHIFT: begin
                bus.EN_PISO_DEB = 1'b1;
                bus.SHIFT_DEB   = 1'b1;
                bus.BUSY        = 1'b1;
                state_nx        = S_CAPT;
            end
            S_CAPT: begin
                bus.BUSY = 1'b1;
                state_nx = S_TX;
            end
            S_FIN: begin
                bus.DONE         = 1'b1;
                bus.CLR_PISO_DEB = 1'b1;
                state_nx         = bus.DEB_REQ ? S_LOAD : S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_deb_uart_framer.sv
// Bench for deb_uart_framer: PISO model feeds payload, UART monitor decodes TXD, frames checked against a table.
module tb_deb_uart_framer;

    localparam int unsigned CPB = 4;
`ifdef DEB_FRAME_CNT_EN
    localparam int unsigned N_OUT = 15;
    localparam int unsigned HDR   = 2;
`else
    localparam int unsigned N_OUT = 14;
    localparam int unsigned HDR   = 1;
`endif
    localparam int unsigned TRACE_LEN = 1 + N_OUT * 10 * CPB + 24;
    localparam int unsigned FRAME_LEN = TRACE_LEN + 1;

    typedef struct {
        logic [15:0]  ssfr;
        logic [15:0]  con;
        logic [15:0]  mac2;
        logic [15:0]  mac1;
        logic [31:0]  dd_da;
        logic [111:0] exp;
        int unsigned  pulse_at;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req = 1'b0;
    logic [7:0] piso_dout;
    logic [7:0] piso_src [12];
    logic [7:0] piso_mem [12];
    int unsigned piso_pos = 0;

    int unsigned tests = 0;
    int unsigned fails = 0;
    int unsigned cyc = 0;
    int unsigned load_cnt = 0, done_cnt = 0, clr_cnt = 0;
    int unsigned load_cyc = 0, done_cyc = 0;
    int unsigned done_clr_err = 0, fram_err = 0;
    logic        trace [$];
    logic [7:0]  bytes [$];
    logic        dact = 1'b0;
    int unsigned dcnt = 0;
    logic [7:0]  dsh = '0;
    logic [7:0]  exp_fcnt = '0;
    vec_t        tbl [3];

    deb_uart_framer_if bus ();

    assign bus.DEB_REQ = req;
    assign bus.D_IN    = piso_dout;

    deb_uart_framer #(
        .CLKS_PER_BIT (CPB),
        .SYNC_BYTE    (8'hA5),
        .N_BYTES      (12)
    ) dut (
        .CLKEXT  (clk),
        .RST_GLO (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // PISO model: load resets the read position, each shift presents the next byte.
    always @(posedge clk) begin
        if (bus.CLR_PISO_DEB === 1'b1) piso_pos <= 0;
        else if (bus.EN_PISO_DEB === 1'b1 && bus.SHIFT_DEB === 1'b0) begin
            piso_mem <= piso_src;
            piso_pos <= 0;
        end else if (bus.EN_PISO_DEB === 1'b1 && bus.SHIFT_DEB === 1'b1) piso_pos <= piso_pos + 1;
    end

    always_comb begin
        piso_dout = 8'h00;
        if (piso_pos >= 1 && piso_pos <= 12) piso_dout = piso_mem[piso_pos - 1];
    end

    always @(negedge clk) begin
        if (bus.EN_PISO_DEB === 1'b1 && bus.SHIFT_DEB === 1'b0) begin
            load_cnt++;
            load_cyc = cyc;
        end
        if (bus.DONE === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
            if (bus.CLR_PISO_DEB !== 1'b1) done_clr_err++;
        end
        if (bus.CLR_PISO_DEB === 1'b1) clr_cnt++;
        if (bus.BUSY === 1'b1) trace.push_back(bus.TXD);
        // 8N1 decoder, sampling at the second cycle of each 4-cycle bit
        if (rst) begin
            dact = 1'b0;
        end else if (!dact) begin
            if (bus.TXD === 1'b0) begin
                dact = 1'b1;
                dcnt = 0;
            end
        end else begin
            dcnt++;
            if (dcnt == 1 && bus.TXD !== 1'b0) begin
                fram_err++;
                dact = 1'b0;
            end else if (dcnt >= 5 && dcnt <= 33 && (dcnt - 1) % 4 == 0) begin
                dsh = {bus.TXD, dsh[7:1]};
            end else if (dcnt == 37) begin
                if (bus.TXD !== 1'b1) fram_err++;
                bytes.push_back(dsh);
                dact = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        tests++;
        if (got !== expv) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, got, expv);
        end
    endtask

    function automatic logic [7:0] tbl_byte(input vec_t v, input int unsigned i);
        return v.exp[(13 - i) * 8 +: 8];
    endfunction

    function automatic logic [7:0] frame_byte(input vec_t v, input int unsigned i, input logic [7:0] fc);
`ifdef DEB_FRAME_CNT_EN
        if (i == 0) return tbl_byte(v, 0);
        if (i == 1) return fc;
        if (i == N_OUT - 1) return tbl_byte(v, 13) ^ fc;
        return tbl_byte(v, i - 1);
`else
        return (fc == fc) ? tbl_byte(v, i) : 8'h00;
`endif
    endfunction

    // Expected TXD per busy cycle: LOAD idle, 4 cycles per bit, 2 idle cycles ahead of each payload byte.
    function automatic int unsigned trace_errs(input vec_t v, input logic [7:0] fc, input int unsigned base);
        int unsigned p = base;
        int unsigned e = 0;
        logic [9:0]  frm;
        if (trace.size() != base + TRACE_LEN) return 9999;
        if (trace[p] !== 1'b1) e++;
        p++;
        for (int unsigned i = 0; i < N_OUT; i++) begin
            if (i >= HDR && i < HDR + 12) begin
                for (int g = 0; g < 2; g++) begin
                    if (trace[p] !== 1'b1) e++;
                    p++;
                end
            end
            frm = {1'b1, frame_byte(v, i, fc), 1'b0};
            for (int k = 0; k < 10; k++) begin
                for (int c = 0; c < CPB; c++) begin
                    if (trace[p] !== frm[k]) e++;
                    p++;
                end
            end
        end
        return e;
    endfunction

    task automatic set_src(input int unsigned k);
        piso_src[0]  = tbl[k].ssfr[15:8];
        piso_src[1]  = tbl[k].ssfr[7:0];
        piso_src[2]  = tbl[k].con[15:8];
        piso_src[3]  = tbl[k].con[7:0];
        piso_src[4]  = tbl[k].mac2[15:8];
        piso_src[5]  = tbl[k].mac2[7:0];
        piso_src[6]  = tbl[k].mac1[15:8];
        piso_src[7]  = tbl[k].mac1[7:0];
        piso_src[8]  = tbl[k].dd_da[31:24];
        piso_src[9]  = tbl[k].dd_da[23:16];
        piso_src[10] = tbl[k].dd_da[15:8];
        piso_src[11] = tbl[k].dd_da[7:0];
    endtask

    task automatic wait_done(input int unsigned pulse_at, input string tag);
        int unsigned n = 0;
        logic seen = 1'b0;
        while (!seen && n < 2000) begin
            @(negedge clk);
            n++;
            if (bus.DONE === 1'b1) seen = 1'b1;
            else if (pulse_at != 0 && n == pulse_at) begin
                req = 1'b1;
                @(negedge clk);
                req = 1'b0;
            end
        end
        #1;
        check({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
    endtask

    task automatic check_frame(input int unsigned k, input int unsigned bb, input int unsigned bt, input string tag);
        check({tag, "_nbytes"}, bytes.size() - bb, N_OUT);
        for (int unsigned i = 0; i < N_OUT; i++) begin
            if (bb + i < bytes.size())
                check($sformatf("%s_byte%0d", tag, i), {24'd0, bytes[bb + i]}, {24'd0, frame_byte(tbl[k], i, exp_fcnt)});
        end
        check({tag, "_len"}, done_cyc - load_cyc + 1, FRAME_LEN);
        check({tag, "_bit_timing_errs"}, trace_errs(tbl[k], exp_fcnt, bt), 0);
        exp_fcnt = exp_fcnt + 8'd1;
    endtask

    task automatic run_frame(input int unsigned k, input string tag);
        int unsigned bb, bt, l0;
        set_src(k);
        @(negedge clk);
        bb = bytes.size();
        bt = trace.size();
        l0 = load_cnt;
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        wait_done(tbl[k].pulse_at, tag);
        check_frame(k, bb, bt, tag);
        check({tag, "_loads"}, load_cnt - l0, 1);
        @(negedge clk);
        check({tag, "_done_single"}, {31'd0, bus.DONE}, 32'd0);
    endtask

    initial begin
        int unsigned bb, bt, l0, d0, c0, n;

        tbl[0] = '{16'hAAAA, 16'h5555, 16'h1234, 16'hABCD, 32'h01020304,
                   {8'hA5, 8'hAA, 8'hAA, 8'h55, 8'h55, 8'h12, 8'h34, 8'hAB, 8'hCD,
                    8'h01, 8'h02, 8'h03, 8'h04, 8'h44}, 0};
        tbl[1] = '{16'hFFFF, 16'h0000, 16'hDEAD, 16'hBEEF, 32'hAABBCCDD,
                   {8'hA5, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
                    8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h22}, 150};
        tbl[2] = '{16'h0001, 16'h8000, 16'h0F0F, 16'hF0F0, 32'h80402001,
                   {8'hA5, 8'h00, 8'h01, 8'h80, 8'h00, 8'h0F, 8'h0F, 8'hF0, 8'hF0,
                    8'h80, 8'h40, 8'h20, 8'h01, 8'h60}, 0};

        // Reset held 3 edges with a request pulse that must be dropped
        rst = 1'b1;
        @(posedge clk); #1 req = 1'b1;
        @(posedge clk); #1 req = 1'b0;
        @(posedge clk);
        @(negedge clk); #1;
        check("rst_txd",   {31'd0, bus.TXD},          32'd1);
        check("rst_busy",  {31'd0, bus.BUSY},         32'd0);
        check("rst_done",  {31'd0, bus.DONE},         32'd0);
        check("rst_en",    {31'd0, bus.EN_PISO_DEB},  32'd0);
        check("rst_shift", {31'd0, bus.SHIFT_DEB},    32'd0);
        check("rst_clr",   {31'd0, bus.CLR_PISO_DEB}, 32'd0);
        check("rst_no_load", load_cnt, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        check("post_rst_no_load", load_cnt, 0);
        check("post_rst_busy", {31'd0, bus.BUSY}, 32'd0);

        for (int unsigned k = 0; k < 3; k++) run_frame(k, $sformatf("vec%0d", k));

        // Request held high through FIN: next frame starts with LOAD on the following cycle
        set_src(0);
        @(negedge clk);
        bb = bytes.size();
        bt = trace.size();
        l0 = load_cnt;
        req = 1'b1;
        wait_done(0, "b2b_a");
        check_frame(0, bb, bt, "b2b_a");
        bb = bytes.size();
        bt = trace.size();
        @(negedge clk); #1;
        check("b2b_load_next", {30'd0, bus.EN_PISO_DEB, bus.SHIFT_DEB}, 32'd2);
        check("b2b_loads", load_cnt - l0, 2);
        req = 1'b0;
        wait_done(0, "b2b_b");
        check_frame(0, bb, bt, "b2b_b");

        // Reset in the middle of payload byte 5
        set_src(0);
        @(negedge clk);
        bb = bytes.size();
        d0 = done_cnt;
        c0 = clr_cnt;
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        n = 0;
        while (bytes.size() - bb < 5 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("midrst_reach_byte5", {31'd0, (bytes.size() - bb >= 5)}, 32'd1);
        repeat (10) @(negedge clk);
        check("midrst_busy_before", {31'd0, bus.BUSY}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_txd",  {31'd0, bus.TXD},         32'd1);
        check("midrst_busy", {31'd0, bus.BUSY},        32'd0);
        check("midrst_en",   {31'd0, bus.EN_PISO_DEB}, 32'd0);
        rst = 1'b0;
        exp_fcnt = 8'd0;
        repeat (60) @(negedge clk);
        #1;
        check("midrst_no_done", done_cnt - d0, 0);
        check("midrst_no_clr",  clr_cnt - c0,  0);
        run_frame(0, "post_midrst_a");
        run_frame(0, "post_midrst_b");

        check("framing_errs", fram_err, 0);
        check("done_without_clr", done_clr_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
